// File: rtl/wbu.sv
// Write-back unit: formats retiring results on entry, buffers them in a small FIFO, and drives the
// register-file write port plus a commit pulse for each popped entry.
module wbu #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned RADDR_W = 5,
    parameter int unsigned DEPTH   = 2
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [XLEN-1:0]    in_pc_i,
    input  logic [RADDR_W-1:0] in_rd_i,
    input  logic               in_rd_wen_i,
    input  logic               in_is_load_i,
    input  logic               in_load_signed_i,
    input  logic [7:0]         in_mask_i,
    input  logic [1:0]         in_addr_lo_i,
    input  logic [XLEN-1:0]    in_rdata_i,
    input  logic [XLEN-1:0]    in_alu_i,
    input  logic               stall_i,
    output logic               rf_wen_o,
    output logic [RADDR_W-1:0] rf_waddr_o,
    output logic [XLEN-1:0]    rf_wdata_o,
    output logic               commit_o,
    output logic [XLEN-1:0]    commit_pc_o,
    output logic               misalign_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [RADDR_W-1:0] rd;
        logic               wen;
        logic               mis;
        logic [XLEN-1:0]    data;
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          in_entry;
    entry_t          head;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic            full, empty, push, pop;
    logic [XLEN-1:0] shifted, ldata;
    logic            is_byte, is_half;

    logic               rf_wen_d, commit_d, misalign_d;
    logic [RADDR_W-1:0] rf_waddr_d;
    logic [XLEN-1:0]    rf_wdata_d, commit_pc_d;

    // Full when the wrap bits differ but the slot indices match.
    assign full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty      = (wr_ptr_q == rd_ptr_q);
    assign in_ready_o = !full;
    assign push       = in_valid_i && !full;
    assign pop        = !empty && !stall_i;
    assign head       = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        shifted = in_rdata_i >> {in_addr_lo_i, 3'b000};
        is_byte = (in_mask_i == 8'h01);
        is_half = (in_mask_i == 8'h03);
        if (is_byte) begin
            ldata = {{(XLEN-8){in_load_signed_i & shifted[7]}}, shifted[7:0]};
        end else if (is_half) begin
            ldata = {{(XLEN-16){in_load_signed_i & shifted[15]}}, shifted[15:0]};
        end else begin
            ldata = shifted;
        end
        in_entry.pc   = in_pc_i;
        in_entry.rd   = in_rd_i;
        in_entry.wen  = in_rd_wen_i;
        in_entry.mis  = in_is_load_i &&
                        ((is_half && in_addr_lo_i == 2'd3) ||
                         (!is_byte && !is_half && in_addr_lo_i != 2'd0));
        in_entry.data = in_is_load_i ? ldata : in_alu_i;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= in_entry;
        end
    end

    always_comb begin
        rf_wen_d    = 1'b0;
        commit_d    = 1'b0;
        misalign_d  = 1'b0;
        rf_waddr_d  = rf_waddr_o;
        rf_wdata_d  = rf_wdata_o;
        commit_pc_d = commit_pc_o;
        if (pop) begin
            rf_wen_d    = head.wen && (head.rd != '0) && !head.mis;
            commit_d    = 1'b1;
            misalign_d  = head.mis;
            rf_waddr_d  = head.rd;
            rf_wdata_d  = head.data;
            commit_pc_d = head.pc;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            rf_wen_o    <= 1'b0;
            commit_o    <= 1'b0;
            misalign_o  <= 1'b0;
            rf_waddr_o  <= '0;
            rf_wdata_o  <= '0;
            commit_pc_o <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            rf_wen_o    <= rf_wen_d;
            commit_o    <= commit_d;
            misalign_o  <= misalign_d;
            rf_waddr_o  <= rf_waddr_d;
            rf_wdata_o  <= rf_wdata_d;
            commit_pc_o <= commit_pc_d;
        end
    end
endmodule

// File: tb/tb_wbu.sv
// Bench for wbu: directed scenarios and random traffic checked against a queue-based model.
module tb_wbu;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_rd_wen, in_is_load, in_load_signed, stall;
    logic [31:0] in_pc, in_rdata, in_alu;
    logic [4:0]  in_rd;
    logic [7:0]  in_mask;
    logic [1:0]  in_addr_lo;
    logic        rf_wen, commit, misalign;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata, commit_pc;

    always #5 clk = ~clk;

    wbu #(.XLEN(32), .RADDR_W(5), .DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_pc_i(in_pc), .in_rd_i(in_rd), .in_rd_wen_i(in_rd_wen), .in_is_load_i(in_is_load),
        .in_load_signed_i(in_load_signed), .in_mask_i(in_mask), .in_addr_lo_i(in_addr_lo),
        .in_rdata_i(in_rdata), .in_alu_i(in_alu), .stall_i(stall), .rf_wen_o(rf_wen),
        .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata), .commit_o(commit),
        .commit_pc_o(commit_pc), .misalign_o(misalign)
    );

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rd;
        bit          wen;
        bit          mis;
        logic [31:0] data;
    } ent_t;

    ent_t q[$];
    int   vectors = 0;
    int   miscompares = 0;
    bit   last_acc;

    logic        exp_rf_wen, exp_commit, exp_mis, exp_ready;
    logic [4:0]  exp_waddr;
    logic [31:0] exp_wdata, exp_pc;
    logic [72:0] obs;

    assign obs = {rf_wen, rf_waddr, rf_wdata, commit, commit_pc, misalign, in_ready};

    function automatic logic [72:0] expv();
        return {exp_rf_wen, exp_waddr, exp_wdata, exp_commit, exp_pc, exp_mis, exp_ready};
    endfunction

    // Result as the instruction set defines it, computed with plain integer arithmetic.
    function automatic ent_t model_entry();
        ent_t e;
        int nbytes;
        longint unsigned v, lim;
        e.pc  = in_pc;
        e.rd  = in_rd;
        e.wen = in_rd_wen;
        e.mis = 1'b0;
        if (!in_is_load) begin
            e.data = in_alu;
        end else begin
            nbytes = (in_mask == 8'h01) ? 1 : (in_mask == 8'h03) ? 2 : 4;
            v      = {32'd0, in_rdata};
            v      = v >> (8 * in_addr_lo);
            lim    = 64'd1 << (8 * nbytes);
            v      = v % lim;
            if (in_load_signed && v >= lim / 2) v = v + (64'd1 << 32) - lim;
            e.data = v[31:0];
            e.mis  = (nbytes == 2 && in_addr_lo == 2'd3) || (nbytes == 4 && in_addr_lo != 2'd0);
        end
        return e;
    endfunction

    task automatic model_reset();
        q.delete();
        exp_rf_wen = 0; exp_commit = 0; exp_mis = 0; exp_ready = 1;
        exp_waddr = '0; exp_wdata = '0; exp_pc = '0;
    endtask

    // Advance one clock, updating the model; returns at the following negedge.
    task automatic step();
        ent_t e;
        int sz = q.size();
        bit acc = in_valid && (sz < DEPTH);
        bit pop = (sz > 0) && !stall;
        exp_commit = 0; exp_rf_wen = 0; exp_mis = 0;
        if (pop) begin
            e = q.pop_front();
            exp_commit = 1;
            exp_rf_wen = e.wen && (e.rd != 0) && !e.mis;
            exp_mis    = e.mis;
            exp_waddr  = e.rd;
            exp_wdata  = e.data;
            exp_pc     = e.pc;
        end
        if (acc) q.push_back(model_entry());
        last_acc = acc;
        @(posedge clk);
        @(negedge clk);
        exp_ready = (q.size() < DEPTH);
    endtask

    task automatic drive(input bit v, input logic [31:0] pc, input logic [4:0] rd, input bit wen,
                         input bit ld, input bit sg, input logic [7:0] mask,
                         input logic [1:0] alo, input logic [31:0] rdata, input logic [31:0] alu);
        in_valid = v; in_pc = pc; in_rd = rd; in_rd_wen = wen; in_is_load = ld;
        in_load_signed = sg; in_mask = mask; in_addr_lo = alo; in_rdata = rdata; in_alu = alu;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        stall = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 8'h0F, 0, 0, 0);
        model_reset();
        repeat (2) @(negedge clk);
        vectors++;
        if (obs !== expv()) begin
            miscompares++;
            $display("FAIL reset_state: got %h want %h", obs, expv());
        end
        rst_n = 1'b1;
    endtask

    task automatic test_alu();
        drive(1, 32'h100, 5'd5, 1, 0, 0, 8'h0F, 0, 0, 32'h1234_5678);
        step();
        vectors++;
        if (obs !== expv()) begin
            miscompares++;
            $display("FAIL alu_accept: got %h want %h", obs, expv());
        end
        in_valid = 0;
        step();
        vectors++;
        if (obs !== expv() || rf_wdata !== 32'h1234_5678 || rf_wen !== 1'b1 || commit !== 1'b1) begin
            miscompares++;
            $display("FAIL alu_commit: got %h want %h", obs, expv());
        end
    endtask

    task automatic test_loads();
        logic [31:0] want [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0};
        bit          wmis [4] = '{0, 0, 0, 1};
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: drive(1, 32'h200, 5'd1, 1, 1, 1, 8'h01, 2'd3, 32'h80FF_7F01, 0);
                1: drive(1, 32'h204, 5'd2, 1, 1, 0, 8'h01, 2'd3, 32'h80FF_7F01, 0);
                2: drive(1, 32'h208, 5'd3, 1, 1, 1, 8'h03, 2'd2, 32'h8001_0000, 0);
                3: drive(1, 32'h20C, 5'd4, 1, 1, 1, 8'h03, 2'd3, 32'h8001_0000, 0);
                default: in_valid = 0;
            endcase
            step();
            vectors++;
            if (obs !== expv()) begin
                miscompares++;
                $display("FAIL load_%0d: got %h want %h", i, obs, expv());
            end
            if (i >= 1 && i <= 4) begin
                vectors++;
                if (commit !== 1'b1 || misalign !== wmis[i-1] || rf_wen !== !wmis[i-1] ||
                    (!wmis[i-1] && rf_wdata !== want[i-1])) begin
                    miscompares++;
                    $display("FAIL load_value_%0d: got data=%h mis=%b wen=%b want data=%h mis=%b",
                             i - 1, rf_wdata, misalign, rf_wen, want[i-1], wmis[i-1]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 7; i++) begin
            if (i < 4) drive(1, 32'h300 + 4 * i, 5'(i), 1, 0, 0, 8'h0F, 0, 0, 32'hA000 + i);
            else in_valid = 0;
            step();
            vectors++;
            if (obs !== expv()) begin
                miscompares++;
                $display("FAIL b2b_%0d: got %h want %h", i, obs, expv());
            end
        end
    endtask

    task automatic test_stall();
        int n = 0;
        stall = 1;
        for (int i = 0; i < 5; i++) begin
            if (n < 3) drive(1, 32'h400 + 4 * n, 5'(7 + n), 1, 0, 0, 8'h0F, 0, 0, 32'hB000 + n);
            step();
            if (last_acc) n++;
            if (n == 3) in_valid = 0;
            vectors++;
            if (obs !== expv()) begin
                miscompares++;
                $display("FAIL stall_%0d: got %h want %h", i, obs, expv());
            end
        end
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_full_ready: got %b want 0", in_ready);
        end
        stall = 0;
        for (int i = 0; i < 6; i++) begin
            if (n < 3) drive(1, 32'h400 + 4 * n, 5'(7 + n), 1, 0, 0, 8'h0F, 0, 0, 32'hB000 + n);
            step();
            if (last_acc) n++;
            if (n == 3) in_valid = 0;
            vectors++;
            if (obs !== expv()) begin
                miscompares++;
                $display("FAIL release_%0d: got %h want %h", i, obs, expv());
            end
        end
    endtask

    task automatic test_reset_mid();
        stall = 1;
        for (int i = 0; i < 2; i++) begin
            drive(1, 32'h500 + 4 * i, 5'd9, 1, 0, 0, 8'h0F, 0, 0, 32'hC000 + i);
            step();
        end
        in_valid = 0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        vectors++;
        if (obs !== expv()) begin
            miscompares++;
            $display("FAIL reset_mid_outputs: got %h want %h", obs, expv());
        end
        @(negedge clk);
        rst_n = 1'b1;
        stall = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (obs !== expv() || commit !== 1'b0 || in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL reset_mid_after_%0d: got %h want %h", i, obs, expv());
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] masks [4] = '{8'h01, 8'h03, 8'h0F, 8'h00};
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(9, 0) < 7, $urandom, 5'($urandom), $urandom_range(1, 0) == 1,
                  $urandom_range(1, 0) == 1, $urandom_range(1, 0) == 1,
                  masks[$urandom_range(3, 0)], 2'($urandom), $urandom, $urandom);
            if (in_mask == 8'h00) in_mask = 8'($urandom);
            stall = ($urandom_range(3, 0) == 0);
            step();
            vectors++;
            if (obs !== expv()) begin
                miscompares++;
                $display("FAIL random_%0d: got %h want %h", i, obs, expv());
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_loads();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
